// File: rtl/board_rand_if.sv
// ============================================================================
// Module      : board_rand_if
// Description : Request/response and board-RAM write bus between the selector,
//               the board randomiser and the game logic's board RAM.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface board_rand_if;
   logic       INITIALIZE_BOARD;
   logic [3:0] SIZE;
   logic [2:0] COLOR_NUM;
   logic       BOARD_READY;
   logic       BUSY;
   logic       WR_EN;
   logic [7:0] WR_ADDR;
   logic [2:0] WR_COLOR;
   logic [2:0] FIRST_COLOR;

   // Selector / game-logic side: issues the request, consumes the writes.
   modport master (
      output INITIALIZE_BOARD, SIZE, COLOR_NUM,
      input  BOARD_READY, BUSY, WR_EN, WR_ADDR, WR_COLOR, FIRST_COLOR
   );

   // Randomiser side: answers the request and drives the writes.
   modport slave (
      input  INITIALIZE_BOARD, SIZE, COLOR_NUM,
      output BOARD_READY, BUSY, WR_EN, WR_ADDR, WR_COLOR, FIRST_COLOR
   );
endinterface

`default_nettype wire

// File: rtl/board_rand.sv
// ============================================================================
// Module      : board_rand
// Description : Fills a SIZE x SIZE Flood-It board with pseudo-random colours,
//               one cell per write strobe, in answer to INITIALIZE_BOARD.
//               Colours come from a free-running LFSR, with bounded rejection
//               sampling and a fold-down fallback on the last allowed draw.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module board_rand #(
   parameter int          MAX_SIZE  = 14,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_DRAWS = 4
) (
   input  wire logic  MASTER_CLOCK,
   input  wire logic  RESET_N,
   board_rand_if.slave bus
);

   // A zero seed would lock the LFSR at zero forever.
   localparam logic [15:0] c_seed     = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [3:0]  c_max_size = 4'(MAX_SIZE);
   localparam int          c_dw       = (MAX_DRAWS > 1) ? $clog2(MAX_DRAWS) : 1;
   localparam logic [c_dw-1:0] c_last_draw = c_dw'(MAX_DRAWS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_state;
   logic [15:0]     r_lfsr;
   logic [3:0]      r_size, w_size;
   logic [2:0]      r_colors, w_colors;
   logic [3:0]      r_row, w_row;
   logic [3:0]      r_col, w_col;
   logic [c_dw-1:0] r_draws, w_draws;
   logic            r_wr_en, w_wr_en;
   logic [7:0]      r_wr_addr, w_wr_addr;
   logic [2:0]      r_wr_color, w_wr_color;
   logic [2:0]      r_first, w_first;
   logic            r_ready, w_ready;

   logic [3:0]      w_size_clamped;
   logic [2:0]      w_colors_clamped;
   logic [2:0]      w_v;
   logic [2:0]      w_sub1;
   logic [2:0]      w_fallback;
   logic            w_take;
   logic            w_last_col;
   logic            w_last_row;
   logic            w_lfsr_fb;

   assign w_size_clamped   = (bus.SIZE < 4'd2)      ? 4'd2 :
                             (bus.SIZE > c_max_size) ? c_max_size : bus.SIZE;
   assign w_colors_clamped = (bus.COLOR_NUM < 3'd3) ? 3'd3 :
                             (bus.COLOR_NUM > 3'd6) ? 3'd6 : bus.COLOR_NUM;

   // Draw value; a draw is taken if in range or if it is the last allowed draw.
   assign w_v        = r_lfsr[2:0];
   assign w_take     = (w_v < r_colors) || (r_draws == c_last_draw);
   // Out-of-range draw folded down by COLOR_NUM, at most twice (7-3-3 = 1).
   assign w_sub1     = w_v - r_colors;
   assign w_fallback = (w_sub1 >= r_colors) ? (w_sub1 - r_colors) : w_sub1;
   assign w_last_col = (r_col == r_size - 4'd1);
   assign w_last_row = (r_row == r_size - 4'd1);

   // Taps 16,14,13,11 of a right-shifting register sit at bits 0,2,3,5.
   assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   // Free-running LFSR: shifts every cycle regardless of state.
   always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
      if (!RESET_N) r_lfsr <= c_seed;
      else          r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
   end

   // State register and registered outputs.
   always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_size     <= 4'd2;
         r_colors   <= 3'd3;
         r_row      <= 4'd0;
         r_col      <= 4'd0;
         r_draws    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 8'd0;
         r_wr_color <= 3'd0;
         r_first    <= 3'd0;
         r_ready    <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_size     <= w_size;
         r_colors   <= w_colors;
         r_row      <= w_row;
         r_col      <= w_col;
         r_draws    <= w_draws;
         r_wr_en    <= w_wr_en;
         r_wr_addr  <= w_wr_addr;
         r_wr_color <= w_wr_color;
         r_first    <= w_first;
         r_ready    <= w_ready;
      end
   end

   // Next-state and next-output logic for the request/fill/done handshake.
   always_comb begin
      w_state    = r_state;
      w_size     = r_size;
      w_colors   = r_colors;
      w_row      = r_row;
      w_col      = r_col;
      w_draws    = r_draws;
      w_wr_en    = 1'b0;
      w_wr_addr  = r_wr_addr;
      w_wr_color = r_wr_color;
      w_first    = r_first;
      w_ready    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.INITIALIZE_BOARD) begin
               w_size   = w_size_clamped;
               w_colors = w_colors_clamped;
               w_row    = 4'd0;
               w_col    = 4'd0;
               w_draws  = '0;
               w_state  = S_FILL;
            end
         end

         S_FILL: begin
            if (!bus.INITIALIZE_BOARD) begin
               w_state = S_IDLE;
            end else if (w_take) begin
               w_wr_en    = 1'b1;
               w_wr_addr  = {r_row, r_col};
               w_wr_color = (w_v < r_colors) ? w_v : w_fallback;
               w_draws    = '0;
               if ((r_row == 4'd0) && (r_col == 4'd0)) w_first = w_wr_color;
               if (w_last_col) begin
                  w_col = 4'd0;
                  w_row = r_row + 4'd1;
               end else begin
                  w_col = r_col + 4'd1;
               end
               if (w_last_col && w_last_row) w_state = S_DONE;
            end else begin
               w_draws = r_draws + 1'b1;
            end
         end

         S_DONE: begin
            // Ready tracks the request; its drop closes the 4-phase handshake.
            w_ready = bus.INITIALIZE_BOARD;
            if (!bus.INITIALIZE_BOARD) w_state = S_IDLE;
         end

         default: w_state = S_IDLE;
      endcase
   end

   assign bus.BUSY        = (r_state == S_FILL);
   assign bus.BOARD_READY = r_ready;
   assign bus.WR_EN       = r_wr_en;
   assign bus.WR_ADDR     = r_wr_addr;
   assign bus.WR_COLOR    = r_wr_color;
   assign bus.FIRST_COLOR = r_first;

endmodule

`default_nettype wire

// File: tb/tb_board_rand.sv
// ============================================================================
// Module      : tb_board_rand
// Description : Self-checking bench for board_rand. A behavioural model turns
//               the LFSR value at accept into the full expected write stream.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_rand;

   localparam int          MAX_SIZE  = 14;
   localparam int          MAX_DRAWS = 4;
   localparam logic [15:0] SEED      = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   board_rand_if bif();

   board_rand #(.MAX_SIZE(MAX_SIZE), .SEED(SEED), .MAX_DRAWS(MAX_DRAWS)) dut (
      .MASTER_CLOCK (clk),
      .RESET_N      (rst_n),
      .bus          (bif.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Expected write stream of one fill: address, colour, FILL cycle number.
   logic [7:0] e_addr[$];
   logic [2:0] e_col[$];
   int         e_cyc[$];
   int         e_total;
   int         e_fb;
   logic [2:0] exp_first = 3'd0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic b;
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {b, l[15:1]};
   endfunction

   function automatic int clamp_size(input int v);
      if (v < 2) return 2;
      if (v > MAX_SIZE) return MAX_SIZE;
      return v;
   endfunction

   function automatic int clamp_col(input int v);
      if (v < 3) return 3;
      if (v > 6) return 6;
      return v;
   endfunction

   // Reference LFSR: reseeded by reset, one step per clock otherwise.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= lfsr_next(m_lfsr);
   end

   // Walk the board row by row, consuming one LFSR value per draw.
   task automatic build_model(input logic [15:0] start, input int s, input int c);
      logic [15:0] l;
      int j, d, v, col;
      bit got;
      e_addr.delete(); e_col.delete(); e_cyc.delete();
      l = start; j = 0; e_fb = 0;
      for (int r = 0; r < s; r++) begin
         for (int cc = 0; cc < s; cc++) begin
            d = 0; got = 0; col = 0;
            while (!got) begin
               j++;
               v = int'(l[2:0]);
               l = lfsr_next(l);
               if (v < c) begin
                  col = v; got = 1;
               end else if (d == MAX_DRAWS - 1) begin
                  col = v - c;
                  if (col >= c) col = col - c;
                  got = 1; e_fb++;
               end else begin
                  d++;
               end
            end
            e_addr.push_back({4'(r), 4'(cc)});
            e_col.push_back(3'(col));
            e_cyc.push_back(j);
         end
      end
      e_total = j;
   endtask

   // One request/fill/ready/drop cycle, optionally aborted after N writes.
   task automatic test_fill(input int size_in, input int col_in, input int gap,
                            input int abort_after, output int nwr, output logic [7:0] last_addr);
      int s, c, wi;
      logic [15:0] st;
      logic exp_wr, exp_busy, exp_ready;
      bit aborted;
      s = clamp_size(size_in); c = clamp_col(col_in);
      nwr = 0; last_addr = 8'd0; wi = 0; aborted = 0;
      repeat (gap) @(negedge clk);
      bif.SIZE = 4'(size_in); bif.COLOR_NUM = 3'(col_in); bif.INITIALIZE_BOARD = 1'b1;
      @(posedge clk); #1;
      st = m_lfsr;
      build_model(st, s, c);
      checks++;
      if (bif.BUSY !== 1'b1) begin
         failures++; $display("FAIL busy_at_accept: got %b want 1", bif.BUSY);
      end
      @(negedge clk);
      bif.SIZE = 4'($urandom); bif.COLOR_NUM = 3'($urandom);
      for (int k = 1; k <= e_total + 1 && !aborted; k++) begin
         @(posedge clk); @(negedge clk);
         exp_wr    = (wi < e_cyc.size()) && (k == e_cyc[wi]);
         exp_busy  = (k < e_total);
         exp_ready = (k == e_total + 1);
         checks++;
         if (bif.WR_EN !== exp_wr) begin
            failures++; $display("FAIL wr_en cycle %0d: got %b want %b", k, bif.WR_EN, exp_wr);
         end
         if (exp_wr) begin
            checks++;
            if (bif.WR_ADDR !== e_addr[wi] || bif.WR_COLOR !== e_col[wi]) begin
               failures++;
               $display("FAIL write %0d: got addr %h col %0d want addr %h col %0d",
                        wi, bif.WR_ADDR, bif.WR_COLOR, e_addr[wi], e_col[wi]);
            end
            if (wi == 0) exp_first = e_col[0];
            wi++;
         end
         if (bif.WR_EN === 1'b1) begin
            nwr++; last_addr = bif.WR_ADDR;
         end
         checks++;
         if (bif.BUSY !== exp_busy) begin
            failures++; $display("FAIL busy cycle %0d: got %b want %b", k, bif.BUSY, exp_busy);
         end
         checks++;
         if (bif.BOARD_READY !== exp_ready) begin
            failures++; $display("FAIL ready cycle %0d: got %b want %b", k, bif.BOARD_READY, exp_ready);
         end
         if (abort_after > 0 && nwr == abort_after) begin
            aborted = 1; bif.INITIALIZE_BOARD = 1'b0;
         end
      end
      if (aborted) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (bif.BUSY !== 1'b0 || bif.WR_EN !== 1'b0) begin
            failures++; $display("FAIL abort_stop: got busy %b wr_en %b want 0 0", bif.BUSY, bif.WR_EN);
         end
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (bif.WR_EN !== 1'b0 || bif.BOARD_READY !== 1'b0) begin
               failures++;
               $display("FAIL abort_quiet: got wr_en %b ready %b want 0 0", bif.WR_EN, bif.BOARD_READY);
            end
         end
      end else begin
         for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (bif.BOARD_READY !== 1'b1 || bif.WR_EN !== 1'b0 || bif.BUSY !== 1'b0) begin
               failures++;
               $display("FAIL ready_hold: got ready %b wr_en %b busy %b want 1 0 0",
                        bif.BOARD_READY, bif.WR_EN, bif.BUSY);
            end
         end
         bif.INITIALIZE_BOARD = 1'b0;
         #1;
         checks++;
         if (bif.BOARD_READY !== 1'b1) begin
            failures++; $display("FAIL ready_before_edge: got %b want 1", bif.BOARD_READY);
         end
         @(posedge clk); @(negedge clk);
         checks++;
         if (bif.BOARD_READY !== 1'b0) begin
            failures++; $display("FAIL ready_drop: got %b want 0", bif.BOARD_READY);
         end
      end
      checks++;
      if (bif.FIRST_COLOR !== exp_first) begin
         failures++; $display("FAIL first_color: got %0d want %0d", bif.FIRST_COLOR, exp_first);
      end
   endtask

   task automatic test_reset();
      bif.INITIALIZE_BOARD = 1'b0; bif.SIZE = 4'd4; bif.COLOR_NUM = 3'd6;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bif.BOARD_READY, bif.BUSY, bif.WR_EN, bif.WR_ADDR, bif.WR_COLOR, bif.FIRST_COLOR} !== 17'd0) begin
         failures++; $display("FAIL reset_outputs: got ready %b busy %b wr %b addr %h col %0d first %0d want all 0",
                              bif.BOARD_READY, bif.BUSY, bif.WR_EN, bif.WR_ADDR, bif.WR_COLOR, bif.FIRST_COLOR);
      end
      rst_n = 1'b1;
      exp_first = 3'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (bif.BUSY !== 1'b0 || bif.WR_EN !== 1'b0 || bif.BOARD_READY !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset: got busy %b wr %b ready %b want 0 0 0",
                              bif.BUSY, bif.WR_EN, bif.BOARD_READY);
      end
   endtask

   task automatic test_basic();
      int n; logic [7:0] a;
      test_fill(4, 6, 0, 0, n, a);
      checks++;
      if (n !== 16 || a !== 8'h33) begin
         failures++; $display("FAIL basic_count: got %0d writes last %h want 16 last 33", n, a);
      end
      // Re-raise: new fill from an advanced LFSR, checked against the model.
      test_fill(4, 6, 1, 0, n, a);
   endtask

   task automatic test_fallback();
      int n; logic [7:0] a;
      int tries = 0;
      bit seen_fb = 0;
      while (!seen_fb && tries < 8) begin
         test_fill(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 0, n, a);
         seen_fb = (e_fb > 0);
         tries++;
      end
   endtask

   task automatic test_clamp();
      int n; logic [7:0] a;
      test_fill(0, 6, 2, 0, n, a);
      checks++;
      if (n !== 4 || a !== 8'h11) begin
         failures++; $display("FAIL clamp_small: got %0d writes last %h want 4 last 11", n, a);
      end
      test_fill(1, 0, 1, 0, n, a);
      checks++;
      if (n !== 4) begin
         failures++; $display("FAIL clamp_one: got %0d writes want 4", n);
      end
      test_fill(15, 7, 3, 0, n, a);
      checks++;
      if (n !== 196 || a !== 8'hDD) begin
         failures++; $display("FAIL clamp_large: got %0d writes last %h want 196 last dd", n, a);
      end
   endtask

   task automatic test_abort();
      int n; logic [7:0] a;
      test_fill(5, int'($urandom_range(3, 6)), 2, 5, n, a);
      checks++;
      if (n !== 5) begin
         failures++; $display("FAIL abort_count: got %0d writes want 5", n);
      end
   endtask

   task automatic test_back_to_back();
      int n; logic [7:0] a;
      for (int i = 0; i < 3; i++) test_fill(3, 4 + i, 0, 0, n, a);
   endtask

   task automatic test_random();
      int n, s, c, ab; logic [7:0] a;
      for (int i = 0; i < 8; i++) begin
         s = int'($urandom_range(0, 15));
         c = int'($urandom_range(0, 7));
         ab = 0;
         if ($urandom_range(0, 3) == 0)
            ab = int'($urandom_range(1, clamp_size(s) * clamp_size(s) - 1));
         test_fill(s, c, int'($urandom_range(0, 6)), ab, n, a);
      end
   endtask

   task automatic test_reset_mid_fill();
      int n; logic [7:0] a;
      bit seen = 0;
      @(negedge clk);
      bif.SIZE = 4'd6; bif.COLOR_NUM = 3'd5; bif.INITIALIZE_BOARD = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bif.WR_EN === 1'b1 && bif.WR_ADDR === 8'h02) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL midfill_wait: got no write to 02 want one within 200 cycles");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bif.WR_EN !== 1'b0 || bif.BUSY !== 1'b0 || bif.BOARD_READY !== 1'b0 || bif.FIRST_COLOR !== 3'd0) begin
         failures++; $display("FAIL async_reset: got wr %b busy %b ready %b first %0d want 0 0 0 0",
                              bif.WR_EN, bif.BUSY, bif.BOARD_READY, bif.FIRST_COLOR);
      end
      bif.INITIALIZE_BOARD = 1'b0;
      exp_first = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      test_fill(6, 5, 2, 0, n, a);
      checks++;
      if (n !== 36 || a !== 8'h55) begin
         failures++; $display("FAIL refill_after_reset: got %0d writes last %h want 36 last 55", n, a);
      end
   endtask

   initial begin
      bif.INITIALIZE_BOARD = 1'b0;
      bif.SIZE = 4'd0;
      bif.COLOR_NUM = 3'd0;
      test_reset();
      test_basic();
      test_fallback();
      test_clamp();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
